// File: rtl/adc_access_arbiter.sv
// adc_access_arbiter: round-robin sharing of one SPI ADC with settle, discard and timeout sequencing
module adc_access_arbiter #(
    parameter int          NREQ    = 3,
    parameter int          SETTLE  = 4,
    parameter int          DISCARD = 3,
    parameter logic [15:0] TIMEOUT = 16'hFFF0
) (
    input  logic              clk3p2M,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_chan,
    input  logic [NREQ-1:0]   req_batt_sel,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [9:0]        rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              adc_go,
    output logic [3:0]        adc_chan,
    output logic              adc_batt_sel,
    input  logic [9:0]        adc_in,
    input  logic              adc_valid
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, GO = 3'd2, WAIT = 3'd3, DONE = 3'd4;
    logic [2:0]    state;
    logic [IW-1:0] rr_ptr, gnt, sel;
    logic [IW:0]   idx;
    logic          found;
    logic [SW-1:0] settle_cnt;
    logic [2:0]    conv_cnt;
    logic [15:0]   timeout_cnt, timeout_nxt;

    // first pending requester at or above rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        sel = rr_ptr;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            idx = (idx >= (IW+1)'(NREQ)) ? idx - (IW+1)'(NREQ) : idx;
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                sel = idx[IW-1:0];
            end
        end
    end

    assign timeout_nxt = timeout_cnt + 16'd1;
    assign req_ack = (state == IDLE && found && !reset) ? NREQ'(1) << sel : '0;
    assign rsp_valid = (state == DONE) ? NREQ'(1) << gnt : '0;
    assign busy = state != IDLE;
    assign adc_go = state == GO;

    always_ff @(posedge clk3p2M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            gnt <= '0;
            settle_cnt <= '0;
            conv_cnt <= '0;
            timeout_cnt <= '0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            adc_chan <= '0;
            adc_batt_sel <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    gnt <= sel;
                    rr_ptr <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
                    adc_chan <= req_chan[4*sel +: 4];
                    adc_batt_sel <= req_batt_sel[sel];
                    conv_cnt <= '0;
                    settle_cnt <= '0;
                    state <= SETUP;
                end
                SETUP: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SW'(SETTLE - 1)) state <= GO;
                end
                GO: begin
                    timeout_cnt <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timeout_cnt <= timeout_nxt;
                    if (timeout_nxt > TIMEOUT) begin
                        rsp_data <= '0;
                        rsp_err <= 1'b1;
                        state <= DONE;
                    end else if (adc_valid) begin
                        if (conv_cnt < 3'(DISCARD)) begin
                            conv_cnt <= conv_cnt + 1'b1;
                            state <= GO;
                        end else begin
                            rsp_data <= adc_in;
                            rsp_err <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_access_arbiter.sv
// tb_adc_access_arbiter: event-logging bench with an ADC model and a round-robin reference model
module tb_adc_access_arbiter;
    localparam int NREQ = 3, SETTLE = 4, DISCARD = 3;
    localparam logic [15:0] TO = 16'h0100;

    logic        clk3p2M = 0, reset = 0;
    logic [2:0]  req_valid = '0, req_batt_sel = '0, rearm = '0;
    logic [11:0] req_chan = '0;
    logic [2:0]  req_ack, rsp_valid;
    logic [9:0]  rsp_data, adc_in = '0, adc_seq = '0;
    logic        rsp_err, busy, adc_go, adc_batt_sel, adc_valid = 0;
    logic [3:0]  adc_chan;
    int checks = 0, failures = 0, cyc_n = 0, multi = 0, cd = 0, adc_lat = 5, adc_mode = 1;

    typedef struct {int cyc; int idx;} ev_t;
    typedef struct {int cyc; int idx; logic [9:0] data; logic err;} rsp_t;
    typedef struct {int cyc; logic [3:0] chan; logic bs;} go_t;
    typedef struct {int cyc; logic [9:0] val;} adcv_t;
    ev_t ack_q[$];
    rsp_t rsp_q[$];
    go_t go_q[$];
    adcv_t adcv_q[$];

    adc_access_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE), .DISCARD(DISCARD), .TIMEOUT(TO)) dut (
        .clk3p2M(clk3p2M), .reset(reset), .req_valid(req_valid), .req_chan(req_chan),
        .req_batt_sel(req_batt_sel), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .adc_go(adc_go), .adc_chan(adc_chan),
        .adc_batt_sel(adc_batt_sel), .adc_in(adc_in), .adc_valid(adc_valid)
    );

    always #5 clk3p2M = ~clk3p2M;

    initial forever begin
        @(negedge clk3p2M);
        cyc_n++;
        if ($countones(req_ack) > 1 || $countones(rsp_valid) > 1) multi++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) ack_q.push_back('{cyc_n, i});
            if (rsp_valid[i]) rsp_q.push_back('{cyc_n, i, rsp_data, rsp_err});
        end
        if (adc_go) go_q.push_back('{cyc_n, adc_chan, adc_batt_sel});
    end

    // ADC: result strobe lands in the WAIT cycle adc_lat cycles after the go cycle
    initial forever begin
        logic f;
        @(negedge clk3p2M);
        adc_valid = 1'b0;
        f = 1'b0;
        if (cd > 0) begin
            cd--;
            f = (cd == 0);
        end
        if (adc_go && adc_mode != 0) cd = adc_lat;
        if (f) begin
            adc_seq = adc_seq + 10'd1;
            adc_in = (adc_mode == 2) ? 10'($urandom) : (adc_mode == 3) ? 10'h2A5 : adc_seq;
            adc_valid = 1'b1;
            adcv_q.push_back('{cyc_n, adc_in});
        end
    end

    function automatic logic [9:0] nth_adc(input int after, input int n);
        int c = 0;
        logic [9:0] v = 'x;
        foreach (adcv_q[i]) if (adcv_q[i].cyc > after) begin
            c++;
            if (c == n) begin
                v = adcv_q[i].val;
                break;
            end
        end
        return v;
    endfunction

    task automatic tick;
        logic [2:0] a;
        @(negedge clk3p2M);
        a = req_ack;
        @(posedge clk3p2M);
        #1;
        req_valid = req_valid & ~(a & ~rearm);
    endtask

    task automatic run(input int n);
        repeat (n) tick;
    endtask

    task automatic run_until(input int n, input int budget, output bit hit);
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick;
            hit = rsp_q.size() >= n;
        end
    endtask

    task automatic apply_reset;
        reset = 1;
        req_valid = '0;
        rearm = '0;
        repeat (2) @(posedge clk3p2M);
        #1 reset = 0;
    endtask

    task automatic test_reset;
        #2 reset = 1;
        req_valid = 3'b111;
        req_chan = 12'hABC;
        req_batt_sel = 3'b111;
        repeat (2) @(posedge clk3p2M);
        @(negedge clk3p2M);
        checks++;
        if ({req_ack, rsp_valid, busy, adc_go, adc_chan, adc_batt_sel, rsp_err, rsp_data} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {req_ack, rsp_valid, busy, adc_go, adc_chan, adc_batt_sel, rsp_err, rsp_data});
        end
        @(posedge clk3p2M);
        #1 req_valid = '0;
        reset = 0;
        run(3);
        checks++;
        if (busy !== 1'b0 || ack_q.size() != 0) begin
            failures++;
            $display("FAIL reset_idle busy=%b acks=%0d exp busy=0 acks=0", busy, ack_q.size());
        end
    endtask

    task automatic test_discard;
        int r0;
        bit hit;
        logic [9:0] s0;
        r0 = rsp_q.size();
        s0 = adc_seq;
        adc_mode = 1;
        adc_lat = 5;
        req_valid = 3'b001;
        run_until(r0 + 1, 400, hit);
        run(10);
        checks++;
        if (!hit || rsp_q.size() != r0 + 1) begin
            failures++;
            $display("FAIL discard_rsp_count got=%0d exp=1", rsp_q.size() - r0);
        end else begin
            checks++;
            if ({rsp_q[r0].err, rsp_q[r0].data} !== {1'b0, s0 + 10'd4}) begin
                failures++;
                $display("FAIL discard_data got=%h err=%b exp=%h err=0", rsp_q[r0].data, rsp_q[r0].err, s0 + 10'd4);
            end
        end
    endtask

    task automatic test_single;
        int a0, r0, ng, bad;
        bit hit;
        logic bs;
        a0 = ack_q.size();
        r0 = rsp_q.size();
        bs = 1'($urandom);
        adc_mode = 3;
        adc_lat = 20;
        req_chan = 12'h050;
        req_batt_sel = {1'b0, bs, 1'b0};
        req_valid = 3'b010;
        run_until(r0 + 1, 500, hit);
        run(10);
        checks++;
        if (!hit || ack_q.size() != a0 + 1 || rsp_q.size() != r0 + 1) begin
            failures++;
            $display("FAIL single_counts acks=%0d rsps=%0d exp 1 1", ack_q.size() - a0, rsp_q.size() - r0);
        end else begin
            checks++;
            if (ack_q[a0].idx != 1 || rsp_q[r0].idx != 1) begin
                failures++;
                $display("FAIL single_idx ack=%0d rsp=%0d exp=1", ack_q[a0].idx, rsp_q[r0].idx);
            end
            checks++;
            if ({rsp_q[r0].err, rsp_q[r0].data} !== 11'h2A5) begin
                failures++;
                $display("FAIL single_data got=%h err=%b exp=2a5 err=0", rsp_q[r0].data, rsp_q[r0].err);
            end
            checks++;
            if (rsp_q[r0].cyc - ack_q[a0].cyc + 1 != 1 + SETTLE + (DISCARD + 1) * (20 + 1) + 1) begin
                failures++;
                $display("FAIL single_latency got=%0d exp=%0d", rsp_q[r0].cyc - ack_q[a0].cyc + 1, 1 + SETTLE + (DISCARD + 1) * 21 + 1);
            end
            ng = 0;
            bad = 0;
            foreach (go_q[i]) if (go_q[i].cyc > ack_q[a0].cyc && go_q[i].cyc < rsp_q[r0].cyc) begin
                ng++;
                if (go_q[i].chan !== 4'd5 || go_q[i].bs !== bs) bad++;
            end
            checks++;
            if (ng != DISCARD + 1 || bad != 0) begin
                failures++;
                $display("FAIL single_go pulses=%0d bad_mux=%0d exp pulses=%0d bad_mux=0", ng, bad, DISCARD + 1);
            end
        end
    endtask

    task automatic test_round_robin;
        int a0, r0, rr_m, e, bad, gap;
        bit hit;
        apply_reset;
        a0 = ack_q.size();
        r0 = rsp_q.size();
        adc_mode = 2;
        adc_lat = $urandom_range(1, 6);
        rearm = 3'b111;
        req_valid = 3'b111;
        run_until(r0 + 6, 800, hit);
        req_valid = '0;
        rearm = '0;
        run(5);
        checks++;
        if (!hit || ack_q.size() != a0 + 6 || rsp_q.size() != r0 + 6) begin
            failures++;
            $display("FAIL rr_counts acks=%0d rsps=%0d exp 6 6", ack_q.size() - a0, rsp_q.size() - r0);
        end else begin
            rr_m = 0;
            bad = 0;
            gap = 0;
            for (int k = 0; k < 6; k++) begin
                e = rr_m;
                rr_m = (e + 1) % NREQ;
                checks++;
                if (ack_q[a0 + k].idx != e || rsp_q[r0 + k].idx != e) begin
                    failures++;
                    $display("FAIL rr_order grant=%0d ack=%0d rsp=%0d exp=%0d", k, ack_q[a0 + k].idx, rsp_q[r0 + k].idx, e);
                end
                if (rsp_q[r0 + k].err !== 1'b0) bad++;
                if (k < 5 && ack_q[a0 + k + 1].cyc != rsp_q[r0 + k].cyc + 1) gap++;
            end
            checks++;
            if (bad != 0 || gap != 0) begin
                failures++;
                $display("FAIL rr_back_to_back errs=%0d late_grants=%0d exp 0 0", bad, gap);
            end
        end
    endtask

    task automatic test_timeout;
        int a0, r0;
        bit hit;
        a0 = ack_q.size();
        r0 = rsp_q.size();
        adc_mode = 0;
        req_valid = 3'b001;
        run_until(r0 + 1, int'(TO) + 100, hit);
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL timeout_rsp got=none exp=rsp_valid");
        end else begin
            checks++;
            if ({rsp_q[r0].idx, rsp_q[r0].err, rsp_q[r0].data} !== {0, 1'b1, 10'd0}) begin
                failures++;
                $display("FAIL timeout_err idx=%0d err=%b data=%h exp idx=0 err=1 data=0", rsp_q[r0].idx, rsp_q[r0].err, rsp_q[r0].data);
            end
            checks++;
            if (rsp_q[r0].cyc - ack_q[a0].cyc != 1 + SETTLE + 1 + (int'(TO) + 1)) begin
                failures++;
                $display("FAIL timeout_latency got=%0d exp=%0d", rsp_q[r0].cyc - ack_q[a0].cyc, 1 + SETTLE + 1 + int'(TO) + 1);
            end
        end
        adc_mode = 1;
        adc_lat = 3;
        a0 = ack_q.size();
        req_valid = 3'b100;
        run_until(r0 + 2, 400, hit);
        checks++;
        if (!hit || ack_q.size() != a0 + 1) begin
            failures++;
            $display("FAIL timeout_recover rsps=%0d exp=1", rsp_q.size() - r0 - 1);
        end else if ({rsp_q[r0 + 1].idx, rsp_q[r0 + 1].err, rsp_q[r0 + 1].data} !== {2, 1'b0, nth_adc(ack_q[a0].cyc, DISCARD + 1)}) begin
            failures++;
            $display("FAIL timeout_recover idx=%0d err=%b data=%h exp idx=2 err=0 data=%h", rsp_q[r0 + 1].idx, rsp_q[r0 + 1].err, rsp_q[r0 + 1].data, nth_adc(ack_q[a0].cyc, DISCARD + 1));
        end
    endtask

    task automatic test_reset_mid;
        int g0, r0, a1;
        bit hit;
        apply_reset;
        g0 = go_q.size();
        r0 = rsp_q.size();
        adc_mode = 1;
        adc_lat = 30;
        req_valid = 3'b010;
        for (int i = 0; i < 50 && go_q.size() == g0; i++) tick;
        run(5);
        @(posedge clk3p2M);
        #3 reset = 1;
        #1;
        checks++;
        if ({req_ack, rsp_valid, busy, adc_go, adc_chan, adc_batt_sel, rsp_err, rsp_data} !== 24'd0 || go_q.size() == g0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h gos=%0d exp=0 gos>0", {req_ack, rsp_valid, busy, adc_go, adc_chan, adc_batt_sel, rsp_err, rsp_data}, go_q.size() - g0);
        end
        req_valid = '0;
        repeat (2) @(posedge clk3p2M);
        #1 reset = 0;
        run(40);
        checks++;
        if (rsp_q.size() != r0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_stale rsps=%0d busy=%b exp 0 0", rsp_q.size() - r0, busy);
        end
        adc_lat = 4;
        a1 = ack_q.size();
        req_valid = 3'b110;
        run_until(r0 + 2, 600, hit);
        checks++;
        if (!hit || ack_q.size() < a1 + 2 || ack_q[a1].idx != 1 || ack_q[a1 + 1].idx != 2) begin
            failures++;
            $display("FAIL midreset_rr first=%0d exp=1", (ack_q.size() > a1) ? ack_q[a1].idx : -1);
        end
    endtask

    task automatic test_pulse;
        int a0, r0, n2;
        bit hit;
        a0 = ack_q.size();
        r0 = rsp_q.size();
        adc_lat = 4;
        req_valid = 3'b001;
        run(2);
        req_valid[2] = 1'b1;
        tick;
        req_valid[2] = 1'b0;
        run_until(r0 + 1, 400, hit);
        run(20);
        n2 = 0;
        for (int i = a0; i < ack_q.size(); i++) if (ack_q[i].idx == 2) n2++;
        for (int i = r0; i < rsp_q.size(); i++) if (rsp_q[i].idx == 2) n2++;
        checks++;
        if (!hit || n2 != 0 || rsp_q.size() != r0 + 1 || ack_q.size() != a0 + 1) begin
            failures++;
            $display("FAIL pulse_ignored events_for_2=%0d acks=%0d rsps=%0d exp 0 1 1", n2, ack_q.size() - a0, rsp_q.size() - r0);
        end
    endtask

    task automatic test_random;
        int rr_m, e, n, a0, r0, ng, bad;
        int exp_q[$];
        bit hit;
        logic [2:0] mask, pend;
        apply_reset;
        rr_m = 0;
        adc_mode = 2;
        for (int it = 0; it < 8; it++) begin
            a0 = ack_q.size();
            r0 = rsp_q.size();
            mask = 3'($urandom_range(1, 7));
            req_chan = 12'($urandom);
            req_batt_sel = 3'($urandom);
            adc_lat = $urandom_range(1, 8);
            n = $countones(mask);
            exp_q.delete();
            pend = mask;
            while (pend != 0) begin
                e = rr_m;
                while (!pend[e]) e = (e + 1) % NREQ;
                pend[e] = 1'b0;
                rr_m = (e + 1) % NREQ;
                exp_q.push_back(e);
            end
            req_valid = mask;
            run_until(r0 + n, 1500, hit);
            checks++;
            if (!hit || ack_q.size() != a0 + n) begin
                failures++;
                $display("FAIL rand_counts iter=%0d acks=%0d rsps=%0d exp=%0d", it, ack_q.size() - a0, rsp_q.size() - r0, n);
                continue;
            end
            for (int k = 0; k < n; k++) begin
                e = exp_q[k];
                checks++;
                if (ack_q[a0 + k].idx != e || rsp_q[r0 + k].idx != e) begin
                    failures++;
                    $display("FAIL rand_grant iter=%0d ack=%0d rsp=%0d exp=%0d", it, ack_q[a0 + k].idx, rsp_q[r0 + k].idx, e);
                end
                checks++;
                if ({rsp_q[r0 + k].err, rsp_q[r0 + k].data} !== {1'b0, nth_adc(ack_q[a0 + k].cyc, DISCARD + 1)}) begin
                    failures++;
                    $display("FAIL rand_data iter=%0d got=%h err=%b exp=%h", it, rsp_q[r0 + k].data, rsp_q[r0 + k].err, nth_adc(ack_q[a0 + k].cyc, DISCARD + 1));
                end
                checks++;
                if (rsp_q[r0 + k].cyc - ack_q[a0 + k].cyc + 1 != 1 + SETTLE + (DISCARD + 1) * (adc_lat + 1) + 1) begin
                    failures++;
                    $display("FAIL rand_latency iter=%0d got=%0d exp=%0d", it, rsp_q[r0 + k].cyc - ack_q[a0 + k].cyc + 1, 1 + SETTLE + (DISCARD + 1) * (adc_lat + 1) + 1);
                end
                ng = 0;
                bad = 0;
                foreach (go_q[i]) if (go_q[i].cyc > ack_q[a0 + k].cyc && go_q[i].cyc < rsp_q[r0 + k].cyc) begin
                    ng++;
                    if (go_q[i].chan !== req_chan[4*e +: 4] || go_q[i].bs !== req_batt_sel[e]) bad++;
                end
                checks++;
                if (ng != DISCARD + 1 || bad != 0) begin
                    failures++;
                    $display("FAIL rand_mux iter=%0d pulses=%0d bad_mux=%0d exp pulses=%0d bad_mux=0", it, ng, bad, DISCARD + 1);
                end
            end
        end
        checks++;
        if (multi != 0) begin
            failures++;
            $display("FAIL onehot multi_cycles=%0d exp=0", multi);
        end
    endtask

    initial begin
        test_reset;
        test_discard;
        test_single;
        test_round_robin;
        test_timeout;
        test_reset_mid;
        test_pulse;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
